// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - aluop codes, FSM states and op decode helpers for ex_muldiv_unit
package muldiv_pkg;

    localparam logic [5:0] OP_MUL    = 6'h20;
    localparam logic [5:0] OP_MULH   = 6'h21;
    localparam logic [5:0] OP_MULHSU = 6'h22;
    localparam logic [5:0] OP_MULHU  = 6'h23;
    localparam logic [5:0] OP_DIV    = 6'h24;
    localparam logic [5:0] OP_DIVU   = 6'h25;
    localparam logic [5:0] OP_REM    = 6'h26;
    localparam logic [5:0] OP_REMU   = 6'h27;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } muldiv_state_t;

    function automatic logic is_muldiv_op(input logic [5:0] op);
        return (op[5:3] == 3'b100);
    endfunction

    function automatic logic is_div_op(input logic [5:0] op);
        return is_muldiv_op(op) && op[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring-divide iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    // multiply: acc = {partial_hi, multiplier}; divide: acc = {remainder, dividend/quotient}
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;
    logic            ge;

    // Single iteration: add-then-shift-right, or shift-left-then-trial-subtract
    always_comb begin
        sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        diff   = rem_sh[XLEN-1:0] - opnd_i;
        ge     = (rem_sh >= {1'b0, opnd_i});
        if (div_i) begin
            acc_o = {(ge ? diff : rem_sh[XLEN-1:0]), acc_i[XLEN-2:0], ge};
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide EX engine (option: MULDIV_EARLY_OUT_EN)
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [XLEN-1:0] data_in_1,
    input  logic [XLEN-1:0] data_in_2,
    input  logic [4:0]      rd_in,
    input  logic [5:0]      aluop_in,
    output logic            ready_out,
    output logic            busy_out,
    output logic            result_valid,
    output logic [XLEN-1:0] result_out,
    output logic [4:0]      rd_out
);

    muldiv_state_t     state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [5:0]        op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic              div0_q;
    logic              prep_q;
    logic              ready_q;
    logic              busy_q;
    logic              rv_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    logic              op_div;
    logic              signed_a;
    logic              signed_b;
    logic              na;
    logic              nb;
    logic              early;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   final_res;
    logic [2*XLEN-1:0] acc_step;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_i  (op_div),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_step)
    );

    // Operand magnitudes for the first BUSY cycle and sign-corrected result for FINAL
    always_comb begin
        op_div   = is_div_op(op_q);
        signed_a = (op_q != OP_MULHU) && (op_q != OP_DIVU) && (op_q != OP_REMU);
        signed_b = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
        na       = signed_a && a_q[XLEN-1];
        nb       = signed_b && b_q[XLEN-1];
        mag_a    = na ? (~a_q + 1'b1) : a_q;
        mag_b    = nb ? (~b_q + 1'b1) : b_q;
`ifdef MULDIV_EARLY_OUT_EN
        early    = (b_q == '0) || (!op_div && (a_q == '0));
`else
        early    = 1'b0;
`endif
        prod     = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
        quot     = div0_q ? '1
                 : ((neg_a_q ^ neg_b_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0]);
        rem      = neg_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       final_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = quot;
            default:                      final_res = rem;
        endcase
    end

    // Control FSM with registered handshake outputs; first BUSY cycle conditions operands
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            div0_q   <= 1'b0;
            prep_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            rv_q     <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prep_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_in && is_muldiv_op(aluop_in)) begin
                        a_q     <= data_in_1;
                        b_q     <= data_in_2;
                        rd_q    <= rd_in;
                        op_q    <= aluop_in;
                        cnt_q   <= CNT_W'(XLEN);
                        prep_q  <= 1'b1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (prep_q) begin
                        prep_q  <= 1'b0;
                        neg_a_q <= na;
                        neg_b_q <= nb;
                        div0_q  <= op_div && (b_q == '0);
                        opnd_q  <= op_div ? mag_b : mag_a;
                        if (early) begin
                            // zero operand: remainder path carries the dividend, quotient forced later
                            acc_q   <= op_div ? {mag_a, {XLEN{1'b1}}} : '0;
                            state_q <= FINAL;
                        end else begin
                            acc_q   <= op_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                        end
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    result_q <= final_res;
                    rd_out_q <= rd_q;
                    busy_q   <= 1'b0;
                    rv_q     <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    rv_q    <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    rv_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ready_out    = ready_q;
    assign busy_out     = busy_q;
    assign result_valid = rv_q & ~flush;
    assign result_out   = result_q;
    assign rd_out       = rd_out_q;

endmodule
